// File: rtl/sc_lane_shift_ctrl.sv
// ---------------------------------------------------------------------------
// sc_lane_shift_ctrl
//
// Control sequencer for one background lane register of the Frogger datapath.
// It sits directly upstream of the lane register and drives that register's
// control inputs. Its jobs are:
//   - pacing car movement with a per-level prescaler,
//   - sequencing clear -> load when a level starts,
//   - issuing figure loads,
//   - tracking the net lane rotation (offset) for the collision logic.
//
// Ports
//   SC_LaneCtrl_CLOCK_50        in   system clock (50 MHz)
//   SC_LaneCtrl_RESET_InHigh    in   asynchronous reset, active-high
//   SC_LaneCtrl_start_In        in   1-cycle pulse, start/restart level_In
//   SC_LaneCtrl_level_In        in   level number, only 1..4 valid
//   SC_LaneCtrl_pause_InLow     in   0 freezes pacing while running
//   SC_LaneCtrl_stop_In         in   1-cycle pulse, stop lane motion
//   SC_LaneCtrl_figure_In       in   non-zero requests a figure load
//   SC_LaneCtrl_clear_OutLow    out  lane register clear (active-low)
//   SC_LaneCtrl_loadLevel_Out   out  lane register loadLevel
//   SC_LaneCtrl_loadFigure_Out  out  lane register loadFigure
//   SC_LaneCtrl_shift_Out       out  lane register shift (01 left, 10 right)
//   SC_LaneCtrl_running_Out     out  high while the lane is in RUN
//   SC_LaneCtrl_offset_OutBUS   out  net rotation since the last level load
// ---------------------------------------------------------------------------
module sc_lane_shift_ctrl #(
    parameter int                     PRESC_WIDTH = 24,
    parameter logic [PRESC_WIDTH-1:0] PERIOD_LVL1 = 24'd12500000,
    parameter logic [PRESC_WIDTH-1:0] PERIOD_LVL2 = 24'd9375000,
    parameter logic [PRESC_WIDTH-1:0] PERIOD_LVL3 = 24'd6250000,
    parameter logic [PRESC_WIDTH-1:0] PERIOD_LVL4 = 24'd3125000,
    parameter bit                     DIR_RIGHT   = 1'b0,
    parameter int                     LANE_WIDTH  = 8,
    parameter int                     OFFS_WIDTH  = 3
) (
    input  logic                  SC_LaneCtrl_CLOCK_50,
    input  logic                  SC_LaneCtrl_RESET_InHigh,
    input  logic                  SC_LaneCtrl_start_In,
    input  logic [2:0]            SC_LaneCtrl_level_In,
    input  logic                  SC_LaneCtrl_pause_InLow,
    input  logic                  SC_LaneCtrl_stop_In,
    input  logic [2:0]            SC_LaneCtrl_figure_In,
    output logic                  SC_LaneCtrl_clear_OutLow,
    output logic [2:0]            SC_LaneCtrl_loadLevel_Out,
    output logic [2:0]            SC_LaneCtrl_loadFigure_Out,
    output logic [1:0]            SC_LaneCtrl_shift_Out,
    output logic                  SC_LaneCtrl_running_Out,
    output logic [OFFS_WIDTH-1:0] SC_LaneCtrl_offset_OutBUS
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        FIG   = 3'd4
    } laneState_t;

    localparam logic [1:0] SHIFT_CODE = DIR_RIGHT ? 2'b10 : 2'b01;

    // The offset register must be able to count one full lane rotation, so
    // its width has to match the lane register width.
    if (OFFS_WIDTH != $clog2(LANE_WIDTH)) begin : g_offsWidthCheck
        $error("sc_lane_shift_ctrl: OFFS_WIDTH must equal clog2(LANE_WIDTH)");
    end

    laneState_t             state_q, state_d;
    logic [2:0]             lvl_q, lvl_d;
    logic [2:0]             fig_q, fig_d;
    logic [PRESC_WIDTH-1:0] period_q, period_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [OFFS_WIDTH-1:0]  offset_q, offset_d;

    logic startValid;
    logic figReq;
    logic tick;

    // Maps a valid level number to its shift period. Only called with a
    // validated level, the default is there to keep the mux complete.
    function automatic logic [PRESC_WIDTH-1:0] periodFor(input logic [2:0] lvl);
        case (lvl)
            3'd1:    periodFor = PERIOD_LVL1;
            3'd2:    periodFor = PERIOD_LVL2;
            3'd3:    periodFor = PERIOD_LVL3;
            3'd4:    periodFor = PERIOD_LVL4;
            default: periodFor = PERIOD_LVL1;
        endcase
    endfunction

    // Request qualification. A start with an out-of-range level is treated
    // as if no start had happened at all, so a simultaneous figure request
    // still gets through. The tick fires on the last prescaler count of a
    // period, and only while pacing is not paused.
    always_comb begin
        startValid = SC_LaneCtrl_start_In &&
                     (SC_LaneCtrl_level_In >= 3'd1) && (SC_LaneCtrl_level_In <= 3'd4);
        figReq     = (SC_LaneCtrl_figure_In != 3'd0);
        tick       = SC_LaneCtrl_pause_InLow && (presc_q == period_q - PRESC_WIDTH'(1));
    end

    // Next-state and output decode. Strobes to the lane register are Moore
    // decoded from the state, except the shift, which has to be suppressed
    // in the same cycle that a stop, figure or restart request wins.
    // Exit priority in RUN is stop, then figure, then start, then tick.
    always_comb begin
        state_d  = state_q;
        lvl_d    = lvl_q;
        fig_d    = fig_q;
        period_d = period_q;
        presc_d  = presc_q;
        offset_d = offset_q;

        SC_LaneCtrl_clear_OutLow   = 1'b1;
        SC_LaneCtrl_loadLevel_Out  = 3'b000;
        SC_LaneCtrl_loadFigure_Out = 3'b000;
        SC_LaneCtrl_shift_Out      = 2'b00;
        SC_LaneCtrl_running_Out    = 1'b0;

        case (state_q)
            IDLE: begin
                if (startValid) begin
                    lvl_d    = SC_LaneCtrl_level_In;
                    period_d = periodFor(SC_LaneCtrl_level_In);
                    state_d  = CLEAR;
                end else if (figReq) begin
                    fig_d   = SC_LaneCtrl_figure_In;
                    state_d = FIG;
                end
            end

            CLEAR: begin
                SC_LaneCtrl_clear_OutLow = 1'b0;
                state_d                  = LOAD;
            end

            LOAD: begin
                SC_LaneCtrl_loadLevel_Out = lvl_q;
                presc_d                   = '0;
                offset_d                  = '0;
                state_d                   = RUN;
            end

            RUN: begin
                SC_LaneCtrl_running_Out = 1'b1;
                if (SC_LaneCtrl_stop_In) begin
                    state_d = IDLE;
                end else if (figReq) begin
                    fig_d   = SC_LaneCtrl_figure_In;
                    state_d = FIG;
                end else if (startValid) begin
                    lvl_d    = SC_LaneCtrl_level_In;
                    period_d = periodFor(SC_LaneCtrl_level_In);
                    state_d  = CLEAR;
                end else if (tick) begin
                    SC_LaneCtrl_shift_Out = SHIFT_CODE;
                    presc_d               = '0;
                    offset_d              = DIR_RIGHT ? offset_q - OFFS_WIDTH'(1)
                                                      : offset_q + OFFS_WIDTH'(1);
                end else if (SC_LaneCtrl_pause_InLow) begin
                    presc_d = presc_q + PRESC_WIDTH'(1);
                end
            end

            FIG: begin
                SC_LaneCtrl_loadFigure_Out = fig_q;
                state_d                    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops the sequencer back to IDLE
    // from anywhere, including the middle of a clear/load sequence, and
    // restores the level-1 pacing period.
    always_ff @(posedge SC_LaneCtrl_CLOCK_50 or posedge SC_LaneCtrl_RESET_InHigh) begin
        if (SC_LaneCtrl_RESET_InHigh) begin
            state_q  <= IDLE;
            lvl_q    <= 3'd0;
            fig_q    <= 3'd0;
            period_q <= PERIOD_LVL1;
            presc_q  <= '0;
            offset_q <= '0;
        end else begin
            state_q  <= state_d;
            lvl_q    <= lvl_d;
            fig_q    <= fig_d;
            period_q <= period_d;
            presc_q  <= presc_d;
            offset_q <= offset_d;
        end
    end

    assign SC_LaneCtrl_offset_OutBUS = offset_q;

endmodule
